// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, ALU op codes, forwarding selects
// and the ID/EX register layout.
package pipe_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int OPCODE_LENGTH  = 4;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [OPCODE_LENGTH-1:0] ALU_AND = 4'b0000;
  localparam logic [OPCODE_LENGTH-1:0] ALU_ADD = 4'b0010;
  localparam logic [OPCODE_LENGTH-1:0] ALU_EQ  = 4'b1000;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic                      valid;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic                      alu_src;
    logic [OPCODE_LENGTH-1:0]  alu_op;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [DATA_WIDTH-1:0]     imm;
  } id_ex_t;

  // The younger producer (MEM) wins over WB; x0 is hard-wired and never forwarded.
  function automatic fwd_sel_t fwd_select(
    input logic [REG_ADDR_WIDTH-1:0] rs,
    input logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input logic                      mem_we,
    input logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input logic                      wb_we
  );
    if (mem_we && (mem_rd != '0) && (mem_rd == rs)) return FWD_MEM;
    if (wb_we && (wb_rd != '0) && (wb_rd == rs))    return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Combinational RAW-hazard comparator: picks the operand source for the
// A (rs1) and B (rs2) paths of the EX stage.
module forwarding_unit
  import pipe_pkg::*;
(
  input  logic [REG_ADDR_WIDTH-1:0] ex_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rs2_i,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd_i,
  input  logic                      mem_reg_write_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
  input  logic                      wb_reg_write_i,
  output fwd_sel_t                  fwd_a_o,
  output fwd_sel_t                  fwd_b_o
);

  assign fwd_a_o = fwd_select(ex_rs1_i, mem_rd_i, mem_reg_write_i, wb_rd_i, wb_reg_write_i);
  assign fwd_b_o = fwd_select(ex_rs2_i, mem_rd_i, mem_reg_write_i, wb_rd_i, wb_reg_write_i);

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use hazard detection. Width parameters must match pipe_pkg.
module ex_operand_stage
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH     = pipe_pkg::DATA_WIDTH,
  parameter int OPCODE_LENGTH  = pipe_pkg::OPCODE_LENGTH,
  parameter int REG_ADDR_WIDTH = pipe_pkg::REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [OPCODE_LENGTH-1:0]  id_alu_op,
  input  logic                      id_alu_src,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      id_mem_write,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic                      mem_reg_write,
  input  logic [DATA_WIDTH-1:0]     mem_result,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      wb_reg_write,
  input  logic [DATA_WIDTH-1:0]     wb_result,
  output logic [DATA_WIDTH-1:0]     ex_src_a,
  output logic [DATA_WIDTH-1:0]     ex_src_b,
  output logic [OPCODE_LENGTH-1:0]  ex_alu_op,
  output logic [DATA_WIDTH-1:0]     ex_store_data,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      ex_valid,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read,
  output logic                      ex_mem_write,
  output logic                      load_use_hazard
);

  id_ex_t ex_q, ex_d;

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d        = '0;
      ex_d.alu_op = ALU_AND;
    end else if (!stall) begin
      ex_d.valid     = id_valid;
      ex_d.reg_write = id_valid & id_reg_write;
      ex_d.mem_read  = id_valid & id_mem_read;
      ex_d.mem_write = id_valid & id_mem_write;
      ex_d.alu_src   = id_alu_src;
      ex_d.alu_op    = id_alu_op;
      ex_d.rs1       = id_rs1;
      ex_d.rs2       = id_rs2;
      ex_d.rd        = id_rd;
      ex_d.rs1_data  = id_rs1_data;
      ex_d.rs2_data  = id_rs2_data;
      ex_d.imm       = id_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  // Index 0 is the A path (rs1), index 1 the B path (rs2).
  fwd_sel_t [1:0]                  fwd_sel;
  logic     [1:0][DATA_WIDTH-1:0]  reg_data;
  logic     [1:0][DATA_WIDTH-1:0]  fwd_data;

  assign reg_data[0] = ex_q.rs1_data;
  assign reg_data[1] = ex_q.rs2_data;

  forwarding_unit u_forwarding_unit (
    .ex_rs1_i        (ex_q.rs1),
    .ex_rs2_i        (ex_q.rs2),
    .mem_rd_i        (mem_rd),
    .mem_reg_write_i (mem_reg_write),
    .wb_rd_i         (wb_rd),
    .wb_reg_write_i  (wb_reg_write),
    .fwd_a_o         (fwd_sel[0]),
    .fwd_b_o         (fwd_sel[1])
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd_mux
      assign fwd_data[gi] = (fwd_sel[gi] == FWD_MEM) ? mem_result :
                            (fwd_sel[gi] == FWD_WB)  ? wb_result  :
                                                       reg_data[gi];
    end
  endgenerate

  assign ex_src_a      = fwd_data[0];
  assign ex_src_b      = ex_q.alu_src ? ex_q.imm : fwd_data[1];
  assign ex_store_data = fwd_data[1];

  assign ex_alu_op    = ex_q.alu_op;
  assign ex_rd        = ex_q.rd;
  assign ex_valid     = ex_q.valid;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;

  // Conservative: rs2 is compared even for instructions that do not read it.
  assign load_use_hazard = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & id_valid &
                           ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: stimulus queues hand-computed
// expectations, a monitor process pops and compares them against the outputs.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [3:0]  id_alu_op;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write;
  logic        stall, flush;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;
  logic [31:0] ex_src_a, ex_src_b, ex_store_data;
  logic [3:0]  ex_alu_op;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .stall(stall), .flush(flush),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .ex_src_a(ex_src_a), .ex_src_b(ex_src_b), .ex_alu_op(ex_alu_op),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .load_use_hazard(load_use_hazard)
  );

  typedef struct {
    string       name;
    logic [31:0] a, b, st;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  ctrl;  // {valid, reg_write, mem_read, mem_write, load_use_hazard}
  } exp_t;

  exp_t sb_q[$];
  event chk_ev;
  int   tests_run    = 0;
  int   tests_failed = 0;

  // Monitor: drains the scoreboard whenever the stimulus marks outputs as presented.
  initial begin
    exp_t e;
    logic [4:0] act_ctrl;
    forever begin
      @(chk_ev);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        act_ctrl = {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard};
        tests_run++;
        if (ex_src_a !== e.a || ex_src_b !== e.b || ex_store_data !== e.st ||
            ex_alu_op !== e.op || ex_rd !== e.rd || act_ctrl !== e.ctrl) begin
          tests_failed++;
          $display("[TB] FAIL %s: got a=%h b=%h st=%h op=%h rd=%0d ctrl=%b, expected a=%h b=%h st=%h op=%h rd=%0d ctrl=%b",
                   e.name, ex_src_a, ex_src_b, ex_store_data, ex_alu_op, ex_rd, act_ctrl,
                   e.a, e.b, e.st, e.op, e.rd, e.ctrl);
        end else begin
          $display("[TB] ok   %s: a=%h b=%h st=%h op=%h rd=%0d ctrl=%b",
                   e.name, ex_src_a, ex_src_b, ex_store_data, ex_alu_op, ex_rd, act_ctrl);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] st, input logic [3:0] op, input logic [4:0] rd,
                            input logic [4:0] ctrl);
    exp_t e;
    #1;
    e.name = name; e.a = a; e.b = b; e.st = st; e.op = op; e.rd = rd; e.ctrl = ctrl;
    sb_q.push_back(e);
    -> chk_ev;
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [3:0] op, input logic src,
                        input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    id_alu_op = op; id_alu_src = src;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic set_fwd(input logic mw_en, input logic [4:0] mrd, input logic [31:0] mres,
                         input logic ww_en, input logic [4:0] wrd, input logic [31:0] wres);
    mem_reg_write = mw_en; mem_rd = mrd; mem_result = mres;
    wb_reg_write = ww_en; wb_rd = wrd; wb_result = wres;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    #12;
    expect_out("reset_state", 32'h0, 32'h0, 32'h0, 4'h0, 5'd0, 5'b00000);
    rst_n = 1'b1;

    // ADD with immediate, no forwarding
    set_id(1, 1, 2, 5, 32'd5, 32'd9, 32'd7, 4'b0010, 1, 1, 0, 0);
    tick();
    expect_out("capture_imm", 32'd5, 32'd7, 32'd9, 4'b0010, 5'd5, 5'b11000);

    // rs1=3 matched by both MEM and WB
    set_id(1, 3, 0, 7, 32'h11, 32'h22, 32'h0, 4'b0010, 0, 1, 0, 0);
    tick();
    set_fwd(1, 3, 32'hAA, 1, 3, 32'hBB);
    expect_out("fwd_mem_over_wb", 32'hAA, 32'h22, 32'h22, 4'b0010, 5'd7, 5'b11000);
    mem_reg_write = 1'b0;
    expect_out("fwd_wb_only", 32'hBB, 32'h22, 32'h22, 4'b0010, 5'd7, 5'b11000);
    set_id(1, 0, 0, 7, 32'h33, 32'h44, 32'h0, 4'b0010, 0, 1, 0, 0);
    tick();
    set_fwd(1, 0, 32'hAA, 1, 0, 32'hBB);
    expect_out("fwd_x0_never", 32'h33, 32'h44, 32'h44, 4'b0010, 5'd7, 5'b11000);
    set_fwd(0, 0, 0, 0, 0, 0);

    // lw x4 in EX, dependent instruction in ID
    set_id(1, 1, 2, 4, 32'h10, 32'h20, 32'h40, 4'b0010, 1, 1, 1, 0);
    tick();
    set_id(1, 8, 4, 9, 32'h0, 32'h0, 32'h0, 4'b0010, 0, 1, 0, 0);
    expect_out("load_use_rs2", 32'h10, 32'h40, 32'h20, 4'b0010, 5'd4, 5'b11101);
    id_valid = 1'b0;
    expect_out("load_use_id_invalid", 32'h10, 32'h40, 32'h20, 4'b0010, 5'd4, 5'b11100);
    id_valid = 1'b1; id_rs1 = 5'd4; id_rs2 = 5'd8;
    expect_out("load_use_rs1", 32'h10, 32'h40, 32'h20, 4'b0010, 5'd4, 5'b11101);
    set_id(1, 1, 2, 0, 32'h10, 32'h20, 32'h40, 4'b0010, 1, 1, 1, 0);
    tick();
    set_id(1, 0, 0, 9, 32'h0, 32'h0, 32'h0, 4'b0010, 0, 1, 0, 0);
    expect_out("load_use_rd0", 32'h10, 32'h40, 32'h20, 4'b0010, 5'd0, 5'b11100);

    // Stall holds, stall+flush bubbles
    set_id(1, 1, 2, 10, 32'h100, 32'h200, 32'h300, 4'b1000, 0, 1, 0, 0);
    tick();
    expect_out("stall_base", 32'h100, 32'h200, 32'h200, 4'b1000, 5'd10, 5'b11000);
    stall = 1'b1;
    set_id(1, 3, 4, 11, 32'hDEAD, 32'hBEEF, 32'h1, 4'b0010, 1, 1, 1, 1);
    tick();
    expect_out("stall_cycle1", 32'h100, 32'h200, 32'h200, 4'b1000, 5'd10, 5'b11000);
    set_id(1, 5, 6, 12, 32'hCAFE, 32'hF00D, 32'h2, 4'b0010, 1, 0, 0, 1);
    tick();
    expect_out("stall_cycle2", 32'h100, 32'h200, 32'h200, 4'b1000, 5'd10, 5'b11000);
    flush = 1'b1;
    tick();
    expect_out("stall_flush_bubble", 32'h0, 32'h0, 32'h0, 4'b0000, 5'd0, 5'b00000);
    stall = 1'b0; flush = 1'b0;

    // Store: B takes immediate, store data takes WB-forwarded rs2
    set_id(1, 1, 6, 12, 32'h5, 32'h66, 32'h77, 4'b0010, 1, 0, 0, 1);
    tick();
    set_fwd(0, 0, 0, 1, 6, 32'h1234);
    expect_out("store_data_fwd", 32'h5, 32'h77, 32'h1234, 4'b0010, 5'd12, 5'b10010);
    set_fwd(0, 0, 0, 0, 0, 0);

    // id_valid=0 masks the control bits
    set_id(0, 1, 2, 13, 32'h1, 32'h2, 32'h0, 4'b0010, 0, 1, 1, 1);
    tick();
    expect_out("invalid_masks_ctrl", 32'h1, 32'h2, 32'h2, 4'b0010, 5'd13, 5'b00000);

    // Asynchronous reset mid-cycle with a valid instruction loaded
    set_id(1, 1, 2, 14, 32'h9, 32'h8, 32'h0, 4'b1000, 0, 1, 0, 0);
    tick();
    expect_out("loaded_before_reset", 32'h9, 32'h8, 32'h8, 4'b1000, 5'd14, 5'b11000);
    rst_n = 1'b0;
    expect_out("async_reset_midcycle", 32'h0, 32'h0, 32'h0, 4'b0000, 5'd0, 5'b00000);
    rst_n = 1'b1;
    tick();
    expect_out("first_capture_after_reset", 32'h9, 32'h8, 32'h8, 4'b1000, 5'd14, 5'b11000);

    #5;
    if (sb_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
